// File: rtl/sequenciador_busca_pkg.sv
// Shared definitions for the fetch/execute sequencer and the opcode decoder:
// sequencer state encoding and the opcodes the sequencer reacts to.
package sequenciador_busca_pkg;

  typedef enum logic [1:0] {
    BUSCA     = 2'b00,
    EXECUTA   = 2'b01,
    ESPERA_IN = 2'b10,
    PARADO    = 2'b11
  } estado_t;

  localparam logic [4:0] OP_IN  = 5'b00010;
  localparam logic [4:0] OP_HLT = 5'b00001;

  localparam int JUMPE_W = 32;

  // An IN instruction cannot commit until the user has confirmed the input.
  function automatic logic bloqueia_in(input logic op_entrada,
                                       input logic entrada_valida);
    return op_entrada & ~entrada_valida;
  endfunction

endpackage

// File: rtl/sequenciador_busca_if.sv
// Bundle between the control unit/decoder side and the fetch sequencer.
// master = control unit side, slave = sequencer.
interface sequenciador_busca_if
  import sequenciador_busca_pkg::*;
#(
  parameter int ENDR_W = 10
);
  logic               jump;
  logic [JUMPE_W-1:0] jumpE;
  logic               halt;
  logic               opEntrada;
  logic               entradaValida;
  logic               continuar;
  logic [ENDR_W-1:0]  pc;
  logic               executa;
  logic               parado;
  logic               aguardandoEntrada;

  modport master (
    output jump, jumpE, halt, opEntrada, entradaValida, continuar,
    input  pc, executa, parado, aguardandoEntrada
  );

  modport slave (
    input  jump, jumpE, halt, opEntrada, entradaValida, continuar,
    output pc, executa, parado, aguardandoEntrada
  );
endinterface

// File: rtl/sequenciador_busca_contador_pc.sv
// Program counter register: loads a branch target or increments with
// natural wrap-around at 2^ENDR_W.
module contador_pc #(
  parameter int              ENDR_W     = 10,
  parameter logic [ENDR_W-1:0] PC_INICIAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_atualiza,
  input  logic              i_salta,
  input  logic [ENDR_W-1:0] i_alvo,
  output logic [ENDR_W-1:0] o_pc
);

  localparam logic [ENDR_W-1:0] UM = {{(ENDR_W-1){1'b0}}, 1'b1};

  logic [ENDR_W-1:0] r_pc;
  logic [ENDR_W-1:0] w_proximo;

  always_comb begin
    w_proximo = r_pc;
    if (i_atualiza) begin
      w_proximo = i_salta ? i_alvo : r_pc + UM;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc <= PC_INICIAL;
    end else begin
      r_pc <= w_proximo;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/sequenciador_busca.sv
// Instruction fetch/execute sequencer: drives the instruction-memory address
// and issues the single-cycle commit strobe that gates architectural writes.
module sequenciador_busca
  import sequenciador_busca_pkg::*;
#(
  parameter int                ENDR_W     = 10,
  parameter logic [ENDR_W-1:0] PC_INICIAL = '0
) (
  input  logic               clock,
  input  logic               reset,
  sequenciador_busca_if.slave bus
);

  estado_t           r_estado;
  estado_t           w_proximo_estado;
  logic              w_executa;
  logic              w_atualiza_pc;
  logic              w_salta;
  logic [ENDR_W-1:0] w_pc;
  logic [ENDR_W-1:0] w_alvo;
  logic [JUMPE_W-ENDR_W-1:0] w_jumpE_unused;

  // Only the low ENDR_W bits of the branch target address instruction memory.
  assign w_alvo         = bus.jumpE[ENDR_W-1:0];
  assign w_jumpE_unused = bus.jumpE[JUMPE_W-1:ENDR_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= BUSCA;
    end else begin
      r_estado <= w_proximo_estado;
    end
  end

  // Priority inside EXECUTA: halt, then a blocked IN, then commit.
  always_comb begin
    w_proximo_estado = r_estado;
    case (r_estado)
      BUSCA: w_proximo_estado = EXECUTA;
      EXECUTA: begin
        if (bus.halt) begin
          w_proximo_estado = PARADO;
        end else if (bloqueia_in(bus.opEntrada, bus.entradaValida)) begin
          w_proximo_estado = ESPERA_IN;
        end else begin
          w_proximo_estado = BUSCA;
        end
      end
      ESPERA_IN: begin
        if (bus.entradaValida) begin
          w_proximo_estado = BUSCA;
        end
      end
      PARADO: begin
        if (bus.continuar) begin
          w_proximo_estado = BUSCA;
        end
      end
      default: w_proximo_estado = BUSCA;
    endcase
  end

  // Commit is a decode of state and decoder lines; parado/aguardandoEntrada
  // depend on the state register alone.
  always_comb begin
    w_executa     = 1'b0;
    w_atualiza_pc = 1'b0;
    w_salta       = 1'b0;
    case (r_estado)
      EXECUTA: begin
        if (!bus.halt && !bloqueia_in(bus.opEntrada, bus.entradaValida)) begin
          w_executa     = 1'b1;
          w_atualiza_pc = 1'b1;
          w_salta       = bus.jump;
        end
      end
      ESPERA_IN: begin
        if (bus.entradaValida) begin
          w_executa     = 1'b1;
          w_atualiza_pc = 1'b1;
          w_salta       = bus.jump;
        end
      end
      PARADO: begin
        w_atualiza_pc = bus.continuar;
      end
      default: begin
        w_executa = 1'b0;
      end
    endcase
  end

  assign bus.executa           = w_executa;
  assign bus.parado            = (r_estado == PARADO);
  assign bus.aguardandoEntrada = (r_estado == ESPERA_IN);
  assign bus.pc                = w_pc;

  contador_pc #(
    .ENDR_W    (ENDR_W),
    .PC_INICIAL(PC_INICIAL)
  ) u_contador_pc (
    .clock     (clock),
    .reset     (reset),
    .i_atualiza(w_atualiza_pc),
    .i_salta   (w_salta),
    .i_alvo    (w_alvo),
    .o_pc      (w_pc)
  );

endmodule

// File: doc/sequenciador_busca.md
Name: sequenciador_busca

Overview:
- Instruction fetch/execute sequencer.
- Consumes the control unit's outputs (jump, jumpE, halt, IN-wait) and produces the program counter for instruction memory.
- Produces the single-cycle commit strobe that gates register-file and data-memory writes.
- Sits between instruction memory (1-cycle synchronous read) and the opcode decoder; it is the control unit's other end.

Parameters:
- ENDR_W, 10, program counter / instruction-memory address width.
- PC_INICIAL, 0, PC value loaded on reset.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- jump  in  1  from control unit; take branch this instruction.
- jumpE  in  32  from control unit; branch target, low ENDR_W bits used.
- halt  in  1  from control unit; current instruction is HLT.
- opEntrada  in  1  current instruction is IN (opcode 5'b00010).
- entradaValida  in  1  one-cycle pulse from the synchronized, debounced user confirm key.
- continuar  in  1  one-cycle pulse; resume from halt.
- pc  out  ENDR_W  instruction-memory address.
- executa  out  1  commit strobe; AND with escreveR/escreveM upstream.
- parado  out  1  high while halted.
- aguardandoEntrada  out  1  high while blocked on an IN.

Behaviour:
- Reset (asynchronous, active-low, effective immediately):
  - pc=PC_INICIAL, state=BUSCA.
  - executa=0, parado=0, aguardandoEntrada=0.
  - Reset mid-instruction aborts it; no executa is issued.
- States: BUSCA, EXECUTA, ESPERA_IN, PARADO. Encoding is in the package.
- BUSCA:
  - pc is stable and memory reads.
  - Always -> EXECUTA on the next edge.
- EXECUTA:
  - Instruction word is valid and decoder outputs are settled; evaluate in priority order.
  - halt=1 -> PARADO. executa stays 0, pc holds (points at the HLT).
  - opEntrada=1 and entradaValida=0 -> ESPERA_IN, executa=0.
  - Otherwise executa=1 for exactly this cycle, pc updates, -> BUSCA.
- ESPERA_IN:
  - aguardandoEntrada=1, pc holds.
  - On entradaValida=1: executa=1 in that same cycle, pc updates, -> BUSCA.
- PARADO:
  - parado=1, pc holds, executa=0.
  - On continuar=1: pc=pc+1, -> BUSCA.
  - continuar outside PARADO is ignored.
- PC update:
  - jump=1 -> pc=jumpE[ENDR_W-1:0]; upper bits are silently discarded.
  - Otherwise pc=pc+1, modulo 2^ENDR_W (wraps from 2^ENDR_W-1 to 0).
- Latency and throughput:
  - Non-blocking instruction takes 2 cycles: BUSCA, then EXECUTA.
  - executa is asserted once per instruction, never twice.
- Simultaneous events:
  - halt and jump both 1: halt wins.
  - opEntrada and jump both 1 (illegal decode): IN path wins; jump applies at commit.
  - entradaValida arriving while in EXECUTA for an IN: commits without entering ESPERA_IN.
  - entradaValida in any state other than EXECUTA/ESPERA_IN: ignored, not latched.
- Outputs are registered or decoded from the state register only. No combinational path exists from inputs to parado or aguardandoEntrada.
- executa is a combinational decode of state and inputs, because the decoder outputs are only valid within EXECUTA/ESPERA_IN.

Decomposition:
- Shared package holds:
  - State encoding constants: BUSCA=2'b00, EXECUTA=2'b01, ESPERA_IN=2'b10, PARADO=2'b11.
  - Opcode constants (OP_IN=5'b00010, OP_HLT=5'b00001), so the decoder and this block share one definition.
- One natural sub-module: contador_pc, the ENDR_W-bit PC register with load (jump target) and increment-with-wrap. The FSM stays in sequenciador_busca.

Test Plan:
- Reset, then four ADD-like instructions (jump=0, halt=0) -> pc goes 0,1,2,3,4 with 2 cycles each; executa pulses once per instruction, 4 pulses total.
- At pc=5, jump=1, jumpE=32'h0000_0403 -> next pc=10'h003; upper bits dropped; executa=1 for one cycle.
- At pc=7, opEntrada=1, no entradaValida for 10 cycles -> aguardandoEntrada=1, pc=7, executa=0. Pulse entradaValida -> executa=1 that cycle, pc=8.
- At pc=9, halt=1 and jump=1 together -> PARADO, parado=1, pc stays 9 for 20 cycles. Pulse continuar -> pc=10, parado=0.
- ENDR_W=10, pc=1023, non-jump instruction -> pc wraps to 0.
- Assert reset (low) mid-EXECUTA and mid-ESPERA_IN -> pc=PC_INICIAL immediately without waiting for a clock; executa never pulses; state BUSCA after release.
